// File: rtl/anemo_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : anemo_meas_sequencer
// Description : Gated edge counter for the anemometer input; latches the
//               count of each window as the wind-speed datum.
// Revision    : 1.0 - initial release
// ============================================================================
module anemo_meas_sequencer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int GATE_MS     = 1000,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_freq,
    input  logic              continu,
    input  logic              start_stop,
    output logic [DATA_W-1:0] data_anemometre,
    output logic              data_valid,
    output logic              new_data,
    output logic              busy,
    output logic              sat
);

    localparam int c_gate_cycles = (CLK_FREQ_HZ / 1000) * GATE_MS;
    localparam int c_gate_w      = $clog2(c_gate_cycles + 1);
    localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(c_gate_cycles - 1);
    localparam logic [DATA_W-1:0]   c_cnt_max   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GATE  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_gate_w-1:0] r_gate_cnt;
    logic [DATA_W-1:0]   r_cnt;
    logic                r_win_sat;
    logic                r_in_meta;
    logic                r_in_sync;
    logic                r_in_hist;
    logic                r_start_q;

    logic w_edge;
    logic w_start_pulse;

    assign w_edge        = r_in_sync & ~r_in_hist;
    assign w_start_pulse = start_stop & ~r_start_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_gate_cnt      <= '0;
            r_cnt           <= '0;
            r_win_sat       <= 1'b0;
            r_in_meta       <= 1'b0;
            r_in_sync       <= 1'b0;
            r_in_hist       <= 1'b0;
            r_start_q       <= 1'b0;
            data_anemometre <= '0;
            data_valid      <= 1'b0;
            new_data        <= 1'b0;
            busy            <= 1'b0;
            sat             <= 1'b0;
        end else begin
            r_in_meta <= in_freq;
            r_in_sync <= r_in_meta;
            r_in_hist <= r_in_sync;
            r_start_q <= start_stop;
            new_data  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_gate_cnt <= '0;
                    r_cnt      <= '0;
                    r_win_sat  <= 1'b0;
                    if (continu || w_start_pulse) begin
                        r_state <= S_GATE;
                        busy    <= 1'b1;
                        // Only a pure single-shot start invalidates the previous result
                        if (!continu) begin
                            data_valid <= 1'b0;
                            sat        <= 1'b0;
                        end
                    end
                end

                S_GATE: begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    if (w_edge) begin
                        if (r_cnt == c_cnt_max) begin
                            r_win_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (r_gate_cnt == c_gate_last) begin
                        r_state <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    data_anemometre <= r_cnt;
                    sat             <= r_win_sat;
                    data_valid      <= 1'b1;
                    new_data        <= 1'b1;
                    r_win_sat       <= 1'b0;
                    r_gate_cnt      <= '0;
                    // An edge seen during the latch cycle opens the next window's count
                    if (continu) begin
                        r_state <= S_GATE;
                        r_cnt   <= {{(DATA_W-1){1'b0}}, w_edge};
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_anemo_meas_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_anemo_meas_sequencer
// Description : Scoreboard bench: expected {sat,data} queued at stimulus time,
//               compared on every new_data pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anemo_meas_sequencer;

    logic       clk;
    logic       reset_n;
    logic       in_freq_a, continu_a, start_a;
    logic [7:0] data_a;
    logic       valid_a, new_data_a, busy_a, sat_a;
    logic       in_freq_b, continu_b, start_b;
    logic [7:0] data_b;
    logic       valid_b, new_data_b, busy_b, sat_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int c0       = 0;

    logic [8:0] exp_q_a[$];
    logic [8:0] exp_q_b[$];
    int         nd_q_a[$];
    int         nd_q_b[$];
    logic [8:0] e_a, e_b;

    // 100-cycle gate
    anemo_meas_sequencer #(.CLK_FREQ_HZ(1000), .GATE_MS(100), .DATA_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_freq(in_freq_a), .continu(continu_a),
        .start_stop(start_a), .data_anemometre(data_a), .data_valid(valid_a),
        .new_data(new_data_a), .busy(busy_a), .sat(sat_a)
    );

    // 1000-cycle gate for the saturation case
    anemo_meas_sequencer #(.CLK_FREQ_HZ(1000), .GATE_MS(1000), .DATA_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_freq(in_freq_b), .continu(continu_b),
        .start_stop(start_b), .data_anemometre(data_b), .data_valid(valid_b),
        .new_data(new_data_b), .busy(busy_b), .sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (new_data_a) begin
            nd_q_a.push_back(cyc);
            if (exp_q_a.size() == 0) begin
                check_val("a_unexpected_new_data", 32'(new_data_a), 32'd0);
            end else begin
                e_a = exp_q_a.pop_front();
                check_val("a_result_sat_data", {23'd0, sat_a, data_a}, {23'd0, e_a});
                check_val("a_valid_on_new_data", 32'(valid_a), 32'd1);
            end
        end
        if (new_data_b) begin
            nd_q_b.push_back(cyc);
            if (exp_q_b.size() == 0) begin
                check_val("b_unexpected_new_data", 32'(new_data_b), 32'd0);
            end else begin
                e_b = exp_q_b.pop_front();
                check_val("b_result_sat_data", {23'd0, sat_b, data_b}, {23'd0, e_b});
                check_val("b_valid_on_new_data", 32'(valid_b), 32'd1);
            end
        end
    end

    initial begin
        reset_n   = 1'b1;
        in_freq_a = 1'b0; continu_a = 1'b0; start_a = 1'b0;
        in_freq_b = 1'b0; continu_b = 1'b0; start_b = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        check_val("rst_data",     32'(data_a),     32'd0);
        check_val("rst_valid",    32'(valid_a),    32'd0);
        check_val("rst_new_data", 32'(new_data_a), 32'd0);
        check_val("rst_busy",     32'(busy_a),     32'd0);
        check_val("rst_sat",      32'(sat_a),      32'd0);
        reset_n = 1'b1;
        repeat (5) tick();

        // Single-shot, 37 pulses; start seen at c0+1, latch edge at c0+102
        nd_q_a.delete();
        exp_q_a.push_back({1'b0, 8'd37});
        for (int t = 0; t <= 130; t++) begin
            tick();
            if (t == 0) c0 = cyc;
            start_a   = (t == 0);
            in_freq_a = (t >= 1 && t <= 73 && (t % 2) == 1);
            if (t == 50) check_val("ss_busy_mid", 32'(busy_a), 32'd1);
        end
        check_val("ss_nd_count", nd_q_a.size(), 32'd1);
        if (nd_q_a.size() != 0) check_val("ss_nd_latency", nd_q_a[0] - c0, 32'd102);
        check_val("ss_busy_after", 32'(busy_a),  32'd0);
        check_val("ss_valid",      32'(valid_a), 32'd1);
        check_val("ss_data",       32'(data_a),  32'd37);

        // Reset at cycle 60 of a window: outputs clear at once, no latch afterwards
        nd_q_a.delete();
        for (int t = 0; t <= 300; t++) begin
            tick();
            start_a   = (t == 0);
            in_freq_a = (t >= 1 && t <= 39 && (t % 2) == 1);
            if (t == 60) begin
                reset_n = 1'b0;
                #1;
                check_val("arst_data",     32'(data_a),     32'd0);
                check_val("arst_valid",    32'(valid_a),    32'd0);
                check_val("arst_new_data", 32'(new_data_a), 32'd0);
                check_val("arst_busy",     32'(busy_a),     32'd0);
                check_val("arst_sat",      32'(sat_a),      32'd0);
            end
            if (t == 63) reset_n = 1'b1;
        end
        check_val("arst_nd_count",  nd_q_a.size(),   32'd0);
        check_val("arst_busy_idle", 32'(busy_a),     32'd0);
        check_val("arst_valid_idle", 32'(valid_a),   32'd0);

        // Continuous, 20 counted edges per window. Rises repeat every 101 cycles at
        // phases 4,9..99; phase 99 lands in each LATCH cycle. The extra rise at
        // t=-1 fills the first window, which has only 100 gate cycles.
        nd_q_a.delete();
        repeat (6) exp_q_a.push_back({1'b0, 8'd20});
        for (int t = -1; t <= 720; t++) begin
            tick();
            if (t == 0) c0 = cyc;
            continu_a = (t >= 0 && t <= 603);
            in_freq_a = (t == -1) ||
                        (t >= 0 && t <= 603 && (t % 101) >= 4 && (((t % 101) - 4) % 5) == 0);
        end
        check_val("cont_nd_count", nd_q_a.size(), 32'd6);
        for (int i = 0; i < nd_q_a.size(); i++) begin
            check_val($sformatf("cont_nd_time%0d", i), nd_q_a[i] - c0, 32'(102 + 101 * i));
        end
        check_val("cont_busy_after", 32'(busy_a), 32'd0);

        // continu dropped at cycle 50: the window still latches, then IDLE
        nd_q_a.delete();
        exp_q_a.push_back({1'b0, 8'd10});
        for (int t = 0; t <= 300; t++) begin
            tick();
            if (t == 0) c0 = cyc;
            continu_a = (t < 50);
            in_freq_a = (t >= 1 && t <= 19 && (t % 2) == 1);
        end
        check_val("cdrop_nd_count", nd_q_a.size(), 32'd1);
        if (nd_q_a.size() != 0) check_val("cdrop_nd_time", nd_q_a[0] - c0, 32'd102);
        check_val("cdrop_busy", 32'(busy_a), 32'd0);

        // Single-shot, no pulses, second start inside the window is ignored
        nd_q_a.delete();
        exp_q_a.push_back({1'b0, 8'd0});
        for (int t = 0; t <= 300; t++) begin
            tick();
            start_a   = (t == 0 || t == 40);
            in_freq_a = 1'b0;
            if (t == 10) begin
                check_val("zero_valid_cleared", 32'(valid_a), 32'd0);
                check_val("zero_busy_mid",      32'(busy_a),  32'd1);
            end
        end
        check_val("zero_nd_count", nd_q_a.size(), 32'd1);
        check_val("zero_valid",    32'(valid_a),  32'd1);
        check_val("zero_data",     32'(data_a),   32'd0);

        // Saturation: 400 pulses in a 1000-cycle gate, then a clean 10-pulse window
        exp_q_b.push_back({1'b1, 8'd255});
        for (int t = 0; t <= 1100; t++) begin
            tick();
            start_b   = (t == 0);
            in_freq_b = (t >= 1 && t <= 799 && (t % 2) == 1);
        end
        check_val("sat_flag", 32'(sat_b), 32'd1);
        exp_q_b.push_back({1'b0, 8'd10});
        for (int t = 0; t <= 1100; t++) begin
            tick();
            start_b   = (t == 0);
            in_freq_b = (t >= 1 && t <= 19 && (t % 2) == 1);
        end
        check_val("sat_nd_count",   nd_q_b.size(), 32'd2);
        check_val("sat_clear_flag", 32'(sat_b),    32'd0);
        check_val("sat_clear_data", 32'(data_b),   32'd10);

        check_val("a_scoreboard_empty", exp_q_a.size(), 32'd0);
        check_val("b_scoreboard_empty", exp_q_b.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
